// File: rtl/turbo_iter_ctrl.sv
// turbo_iter_ctrl: iteration scheduler for the max-product turbo decoder.
//
// Takes one code block at a time. It runs the shared SISO decoder for the
// configured number of half-iterations, alternating encoder 1 (natural
// order) and encoder 2 (interleaved order). After each SISO pass it makes
// one interleaver pass over the extrinsic memory. At the end it streams the
// N hard-decision addresses out under backpressure.
//
// Parameters
//   N          block length / extrinsic and hard-decision memory depth
//   HALF_ITER  half-iteration count used when cfg_half_iter == 0
//   AW         address width, derived from N
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid / in_ready         block handshake (in_ready = idle)
//   cfg_half_iter               half-iteration count, sampled on accept
//   siso_start/sel/done         SISO pass control (sel: 0 = enc1, 1 = enc2)
//   perm_valid/addr/dir         interleaver pass beats (dir: 0 fwd, 1 rev)
//   out_valid/ready/last        hard-decision stream handshake
//   hd_addr                     hard-decision read address
//   hi_count                    half-iterations completed for this block
//   busy                        controller owns a block
//   hd_changed                  SISO reports a changed hard decision
//
// Optional feature, enabled by defining EARLY_STOP_EN:
//   When hd_changed is 0 on siso_done and hi_count >= 1, the current
//   interleaver pass is finished and the controller goes to OUT early.
//   It then pulses early_stop for one cycle on entry to OUT. Without the
//   macro, hd_changed is ignored and the early_stop port does not exist.
module turbo_iter_ctrl #(
  parameter  int N         = 64,
  parameter  int HALF_ITER = 1,
  localparam int AW        = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    cfg_half_iter,
  output logic          siso_start,
  output logic          siso_sel,
  input  logic          siso_done,
  output logic          perm_valid,
  output logic [AW-1:0] perm_addr,
  output logic          perm_dir,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic [AW-1:0] hd_addr,
  output logic [7:0]    hi_count,
  output logic          busy,
  input  logic          hd_changed
`ifdef EARLY_STOP_EN
  ,
  output logic          early_stop
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    PERM,
    OUT
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] target;
  logic [7:0] hi_inc;
  logic       alive;      // low until the first clock edge after reset
  logic       accept;
  logic       perm_last;
  logic       stop_req;
  logic       done_all;

  // Saturating increment of the half-iteration counter.
  assign hi_inc    = (hi_count == 8'hFF) ? hi_count : hi_count + 8'd1;
  assign accept    = (state == IDLE) && alive && in_valid;
  assign perm_last = (state == PERM) && (perm_addr == AW'(N - 1));
  assign done_all  = (hi_inc == target) || stop_req;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (siso_done) state_nxt = PERM;
      PERM:    if (perm_last) state_nxt = done_all ? OUT : START;
      OUT:     if (out_ready && out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      alive     <= 1'b0;
      target    <= '0;
      hi_count  <= '0;
      perm_addr <= '0;
      hd_addr   <= '0;
    end else begin
      state <= state_nxt;
      alive <= 1'b1;
      unique case (state)
        IDLE: begin
          if (accept) begin
            target   <= (cfg_half_iter == 8'd0) ? 8'(HALF_ITER) : cfg_half_iter;
            hi_count <= '0;
          end
        end
        WAIT: begin
          if (siso_done) perm_addr <= '0;
        end
        PERM: begin
          perm_addr <= perm_last ? '0 : perm_addr + AW'(1);
          if (perm_last) begin
            hi_count <= hi_inc;
            if (done_all) hd_addr <= '0;
          end
        end
        OUT: begin
          if (out_ready) hd_addr <= out_last ? '0 : hd_addr + AW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef EARLY_STOP_EN
  logic stop_q;
  logic es_q;

  // The stop decision is taken on siso_done but only acted on at the end
  // of the following interleaver pass, so the extrinsics stay consistent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stop_q <= 1'b0;
      es_q   <= 1'b0;
    end else begin
      if (state == IDLE) begin
        stop_q <= 1'b0;
      end else if ((state == WAIT) && siso_done) begin
        stop_q <= !hd_changed && (hi_count != 8'd0);
      end
      es_q <= perm_last && stop_q && (hi_inc != target);
    end
  end

  assign stop_req   = stop_q;
  assign early_stop = es_q;
`else
  logic hd_changed_unused;
  assign stop_req          = 1'b0;
  assign hd_changed_unused = hd_changed;
`endif

  assign in_ready   = alive && (state == IDLE);
  assign busy       = alive && (state != IDLE);
  assign siso_start = (state == START);
  assign siso_sel   = ((state == START) || (state == WAIT)) && hi_count[0];
  assign perm_valid = (state == PERM);
  assign perm_dir   = (state == PERM) && hi_count[0];
  assign out_valid  = (state == OUT);
  assign out_last   = (state == OUT) && (hd_addr == AW'(N - 1));

endmodule

// File: tb/tb_turbo_iter_ctrl.sv
// Scoreboard testbench for turbo_iter_ctrl (N = 64, HALF_ITER = 1).
// Expected SISO starts, interleaver beats and output beats are queued when
// a block is accepted. A monitor pops and compares them as the DUT emits.
`timescale 1ns/1ps
module tb_turbo_iter_ctrl;
  localparam int N  = 64;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    cfg_half_iter = 8'd0;
  logic          siso_done = 1'b0;
  logic          out_ready = 1'b1;
  logic          hd_changed = 1'b1;
  logic          in_ready, siso_start, siso_sel, perm_valid, perm_dir;
  logic          out_valid, out_last, busy;
  logic [AW-1:0] perm_addr, hd_addr;
  logic [7:0]    hi_count;
`ifdef EARLY_STOP_EN
  logic          early_stop;
`endif

  turbo_iter_ctrl #(.N(N), .HALF_ITER(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .cfg_half_iter(cfg_half_iter), .siso_start(siso_start), .siso_sel(siso_sel),
    .siso_done(siso_done), .perm_valid(perm_valid), .perm_addr(perm_addr),
    .perm_dir(perm_dir), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .hd_addr(hd_addr), .hi_count(hi_count), .busy(busy),
    .hd_changed(hd_changed)
`ifdef EARLY_STOP_EN
    , .early_stop(early_stop)
`endif
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  bit          rst_edge = 1'b0;

  // stimulus knobs
  int cur_L = 10;
  bit spur = 1'b0;
  int hdc_zero_from = 1000;
  bit tog = 1'b0;

  // scoreboard state
  int          start_q[$];
  int          perm_q[$];
  int          out_q[$];
  int          exp_hi, exp_es, es_cnt;
  int unsigned exp_lat, acc_cyc;
  bit          active = 1'b0;
  bit          first_out = 1'b0;
  logic        last_sel = 1'b0;
  int          accepts = 0;
  int          blocks_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: DUT produced a beat, expected none (t=%0t)", name, $time);
  endtask

  task automatic push_block();
    int t, p;
    t = (cfg_half_iter == 8'd0) ? 1 : int'(cfg_half_iter);
    p = t;
    exp_es = 0;
`ifdef EARLY_STOP_EN
    begin
      int z;
      z = (hdc_zero_from < 1) ? 1 : hdc_zero_from;
      if (z + 1 < t) begin
        p = z + 1;
        exp_es = 1;
      end
    end
`endif
    for (int i = 0; i < p; i++) begin
      start_q.push_back(i % 2);
      for (int a = 0; a < N; a++) perm_q.push_back((i % 2) * N + a);
    end
    for (int a = 0; a < N; a++) out_q.push_back(((a == N - 1) ? N : 0) + a);
    exp_hi    = p;
    exp_lat   = 32'(1 + p * (1 + cur_L + N));
    acc_cyc   = cyc;
    active    = 1'b1;
    first_out = 1'b1;
    es_cnt    = 0;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    rst_edge = rst_n;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // SISO model: done pulse cur_L cycles after start, optional stray done
  // during the START cycle.
  initial forever begin
    @(negedge clk);
    if (rst_n && siso_start) begin
      if (spur) begin
        siso_done = 1'b1;
        @(posedge clk);
        #1 siso_done = 1'b0;
        repeat (cur_L - 1) @(posedge clk);
      end else begin
        repeat (cur_L) @(posedge clk);
      end
      #1 siso_done = 1'b1;
      hd_changed = (int'(hi_count) >= hdc_zero_from) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1 siso_done = 1'b0;
      hd_changed = 1'b1;
    end
  end

  initial forever begin
    @(posedge clk);
    #1 out_ready = tog ? ~out_ready : 1'b1;
  end

  // monitor
  initial forever begin
    int e;
    @(negedge clk);
    if (!rst_n) begin
      start_q.delete();
      perm_q.delete();
      out_q.delete();
      active = 1'b0;
      first_out = 1'b0;
    end else begin
      check("in_ready", in_ready, rst_edge && !active);
      check("busy", busy, rst_edge && active);
      if (in_valid && in_ready) begin
        accepts++;
        push_block();
      end
`ifdef EARLY_STOP_EN
      if (early_stop) es_cnt++;
`endif
      if (siso_start) begin
        if (start_q.size() == 0) unexpected("siso_start");
        else begin
          e = start_q.pop_front();
          check("siso_sel at start", siso_sel, e);
          last_sel = siso_sel;
        end
      end else if (siso_done) begin
        check("siso_sel held to done", siso_sel, last_sel);
      end
      if (perm_valid) begin
        if (perm_q.size() == 0) unexpected("perm beat");
        else begin
          e = perm_q.pop_front();
          check("perm dir/addr", {perm_dir, perm_addr}, e);
        end
      end
      if (out_valid) begin
        if (first_out) begin
          check("accept-to-out latency", cyc - acc_cyc, exp_lat);
          first_out = 1'b0;
        end
        if (out_ready) begin
          if (out_q.size() == 0) unexpected("out beat");
          else begin
            e = out_q.pop_front();
            check("out last/addr", {out_last, hd_addr}, e);
            if (out_last) begin
              check("hi_count at end", hi_count, exp_hi);
              check("queues drained", start_q.size() + perm_q.size() + out_q.size(), 0);
`ifdef EARLY_STOP_EN
              check("early_stop pulses", es_cnt, exp_es);
`endif
              active = 1'b0;
              blocks_done++;
            end
          end
        end
      end
    end
  end

  task automatic wait_accept(input int n);
    int t;
    t = 0;
    while (accepts < n && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("block accepted in time", accepts >= n, 1);
  endtask

  task automatic wait_done(input int n);
    int t;
    t = 0;
    while (blocks_done < n && t < 5000) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("block completed in time", blocks_done >= n, 1);
  endtask

  task automatic run_block(input int cfg, input int lat, input bit sp, input int z, input bit tg);
    int base, a0;
    base = blocks_done;
    a0 = accepts;
    cfg_half_iter = 8'(cfg);
    cur_L = lat;
    spur = sp;
    hdc_zero_from = z;
    tog = tg;
    in_valid = 1'b1;
    wait_accept(a0 + 1);
    in_valid = 1'b0;
    wait_done(base + 1);
  endtask

  initial begin
    int b, a, t;
    repeat (2) @(negedge clk);
    check("reset outputs", {siso_start, siso_sel, perm_valid, perm_addr, perm_dir,
                            out_valid, out_last, hd_addr, hi_count}, 0);
    check("reset in_ready", in_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_block(0, 10, 1'b0, 1000, 1'b0);   // HALF_ITER default, 76-cycle latency
    run_block(4, 3, 1'b1, 1000, 1'b0);    // sel/dir 0,1,0,1, stray done in START
    run_block(2, 5, 1'b0, 1000, 1'b1);    // out_ready toggling

    // in_valid held high across two blocks
    b = blocks_done;
    a = accepts;
    cfg_half_iter = 8'd1;
    cur_L = 4;
    spur = 1'b0;
    tog = 1'b0;
    in_valid = 1'b1;
    wait_done(b + 2);
    in_valid = 1'b0;
    check("accepts while in_valid held", accepts - a, 2);

    // reset in the middle of an interleaver pass
    cfg_half_iter = 8'd2;
    cur_L = 4;
    in_valid = 1'b1;
    wait_accept(accepts + 1);
    in_valid = 1'b0;
    t = 0;
    while (!(perm_valid && perm_addr == AW'(30)) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("perm_addr reached 30", perm_addr, 30);
    #2 rst_n = 1'b0;
    #1;
    check("async reset outputs", {siso_start, siso_sel, perm_valid, perm_addr, perm_dir,
                                  out_valid, out_last, hd_addr, hi_count}, 0);
    check("async reset in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("in_ready after reset", in_ready, 1);
    @(posedge clk);
    #1;
    run_block(3, 6, 1'b0, 1000, 1'b0);    // normal block after abort

    // hd_changed low from the second pass onwards, cfg = 8
    run_block(8, 2, 1'b0, 1, 1'b0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached before test end");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
